// File: rtl/uart_tx_frame.sv
// UART transmitter: one bit per clk cycle, framing start + LSB-first data + optional parity + stop.
// Define UART_TX_PARITY_EN to compile in the parity bit; otherwise par_en/par_typ are ignored.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy
);
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d, cnt_nxt;
  logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_en_d;
  logic par_typ_q, par_typ_d;
`else
  logic unused_par;
  assign unused_par = par_en ^ par_typ;
`endif

  assign cnt_nxt = cnt_q + 1'b1;

  // Outputs are registered from the next state, so tx_out/busy always reflect the current state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    tx_d     = 1'b1;
    busy_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
`endif
    case (state_q)
      IDLE: begin
        if (data_valid) begin
          shadow_d = p_data;
`ifdef UART_TX_PARITY_EN
          par_en_d  = par_en;
          par_typ_d = par_typ;
`endif
          state_d  = START;
          tx_d     = 1'b0;
          busy_d   = 1'b1;
        end
      end
      START: begin
        state_d = DATA;
        cnt_d   = '0;
        tx_d    = shadow_q[0];
        busy_d  = 1'b1;
      end
      DATA: begin
        busy_d = 1'b1;
        if (cnt_q == LAST) begin
`ifdef UART_TX_PARITY_EN
          if (par_en_q) begin
            state_d = PARITY;
            tx_d    = (^shadow_q) ^ par_typ_q;
          end else begin
            state_d = STOP;
          end
`else
          state_d = STOP;
`endif
        end else begin
          cnt_d = cnt_nxt;
          tx_d  = shadow_q[cnt_nxt];
        end
      end
      PARITY: begin
        state_d = STOP;
        busy_d  = 1'b1;
      end
      STOP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
`endif
    end
  end

  assign tx_out = tx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: queue-based frame model checked every cycle plus literal frames.
module tb_uart_tx_frame;
  localparam int W = 8;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] p_data = '0;
  logic         data_valid = 1'b0;
  logic         par_en = 1'b0;
  logic         par_typ = 1'b0;
  logic         tx_out, busy;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .p_data(p_data), .data_valid(data_valid),
    .par_en(par_en), .par_typ(par_typ), .tx_out(tx_out), .busy(busy)
  );

  task automatic check(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_v(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Reference model: a frame is the list of line bits; an accepted request expands into it.
  bit   q[$];
  logic e_tx = 1'b1;
  logic e_busy = 1'b0;

  task automatic build(input logic [W-1:0] d, input logic pe, input logic pt);
    q.push_back(1'b0);
    for (int i = 0; i < W; i++) q.push_back(d[i]);
    if (PAR && pe) q.push_back((^d) ^ pt);
    q.push_back(1'b1);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      e_tx = 1'b1; e_busy = 1'b0; chk_en = 1'b1;
    end else if (q.size() > 0) begin
      e_tx = q.pop_front(); e_busy = 1'b1;
    end else if (e_busy) begin
      e_tx = 1'b1; e_busy = 1'b0;  // the one mandatory idle cycle after a stop bit
    end else if (data_valid) begin
      build(p_data, par_en, par_typ);
      e_tx = q.pop_front(); e_busy = 1'b1;
    end else begin
      e_tx = 1'b1; e_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_tx", tx_out, e_tx);
      check("model_busy", busy, e_busy);
    end
  end

  // Issue one request, scramble the inputs mid-frame, capture n line bits (first bit ends up MSB).
  task automatic send_cap(input logic [W-1:0] d, input logic pe, input logic pt, input int n,
                          output logic [63:0] cap, output int nb);
    @(negedge clk);
    p_data = d; par_en = pe; par_typ = pt; data_valid = 1'b1;
    cap = '0; nb = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      data_valid = 1'b0;
      p_data = W'($urandom); par_en = 1'($urandom); par_typ = 1'($urandom);
      cap = {cap[62:0], tx_out};
      nb += int'(busy);
    end
  endtask

  task automatic idle(input int n);
    data_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  logic [63:0] cap;
  int          nb;
  int          nf;

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_tx", tx_out, 1'b1);
      check("idle_busy", busy, 1'b0);
    end

    // 0xA5 even parity
    nf = PAR ? 11 : 10;
    send_cap(8'hA5, 1'b1, 1'b0, nf, cap, nb);
    check_v("a5_frame", cap, PAR ? 64'b01010010101 : 64'b0101001011);
    check_v("a5_busy_len", 64'(nb), 64'(nf));
    @(negedge clk);
    check("a5_busy_fall", busy, 1'b0);
    idle(2);

    // odd parity on 0x01 and 0x00
    send_cap(8'h01, 1'b1, 1'b1, nf, cap, nb);
    check_v("odd01_frame", cap, PAR ? 64'b01000000001 : 64'b0100000001);
    check_v("odd01_len", 64'(nb), 64'(nf));
    idle(3);
    send_cap(8'h00, 1'b1, 1'b1, nf, cap, nb);
    check_v("odd00_frame", cap, PAR ? 64'b00000000011 : 64'b0000000001);
    check_v("odd00_len", 64'(nb), 64'(nf));
    idle(3);

    // held request: three 0x3C frames, one idle cycle between, 11-cycle period
    @(negedge clk);
    p_data = 8'h3C; par_en = 1'b0; par_typ = 1'b0; data_valid = 1'b1; cap = '0;
    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      if (i == 22) data_valid = 1'b0;
      cap = {cap[62:0], tx_out};
    end
    check_v("held_3c", cap, {31'd0, 10'b0001111001, 1'b1, 10'b0001111001, 1'b1, 10'b0001111001, 1'b1});
    idle(2);

    // mid-frame data change and request pulse are ignored
    @(negedge clk);
    p_data = 8'hFF; par_en = 1'b0; data_valid = 1'b1; cap = '0; nb = 0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (i == 0) data_valid = 1'b0;
      if (i == 3) begin p_data = 8'h00; data_valid = 1'b1; end
      if (i == 4) data_valid = 1'b0;
      cap = {cap[62:0], tx_out};
      nb += int'(busy);
    end
    check_v("ff_ignore", cap, 64'b0111111111111);
    check_v("ff_busy_len", 64'(nb), 64'd10);

    // reset during data bit 3 abandons the frame
    @(negedge clk);
    p_data = 8'hFF; par_en = 1'b0; data_valid = 1'b1; cap = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) data_valid = 1'b0;
      if (i == 2) begin p_data = 8'h00; data_valid = 1'b1; end
      if (i == 3) data_valid = 1'b0;
      cap = {cap[62:0], tx_out};
    end
    check_v("rst_partial", cap, 64'b01111);
    rst = 1'b1;
    @(negedge clk);
    check("rst_tx", tx_out, 1'b1);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    send_cap(8'h5A, 1'b0, 1'b0, 10, cap, nb);
    check_v("post_rst_frame", cap, 64'b0010110101);
    idle(3);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      data_valid = ($urandom_range(0, 9) < 4);
      p_data = W'($urandom); par_en = 1'($urandom); par_typ = 1'($urandom);
      if ($urandom_range(0, 499) == 0) rst = 1'b1; else rst = 1'b0;
    end
    rst = 1'b0;
    idle(15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
